// File: rtl/if_write_addr_gen.sv
// IF scratchpad write-side address generator.
// Pops tagged words {start_flag, end_flag, data} from the input FIFO and writes
// them into the circular IF scratchpad. Publishes the row window and the write
// pointer for the read side, and tracks how many written entries the read side
// has not yet released.
module if_write_addr_gen #(
   parameter int IF_ADDR_LEN      = 4,
   parameter int IF_SCRATCH_DEPTH = 16,
   parameter int IF_SCRATCH_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [IF_SCRATCH_WIDTH+1:0] in_data,
   output logic                        in_ready,
   input  logic                        stall_pipeline,
   input  logic [IF_ADDR_LEN-1:0]      stride_len,
   input  logic                        stride_done,
   input  logic                        row_done,
   output logic                        IF_wen,
   output logic [IF_ADDR_LEN-1:0]      IF_waddr,
   output logic [IF_SCRATCH_WIDTH-1:0] IF_wdata,
   output logic [IF_ADDR_LEN-1:0]      IF_start_pos,
   output logic [IF_ADDR_LEN-1:0]      IF_end_pos,
   output logic                        IF_end_valid,
   output logic                        row_start,
   output logic                        full,
   output logic [IF_ADDR_LEN:0]        occupancy,
   output logic                        protocol_err
);

   localparam int OW = IF_ADDR_LEN + 1;
   localparam logic [OW-1:0]          DEPTH_V   = OW'(IF_SCRATCH_DEPTH);
   localparam logic [IF_ADDR_LEN-1:0] LAST_ADDR = IF_ADDR_LEN'(IF_SCRATCH_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ROW} state_t;

   state_t                  state;
   logic [IF_ADDR_LEN-1:0]  waddr;
   logic [IF_ADDR_LEN-1:0]  waddr_inc;
   logic [OW-1:0]           occ;
   logic [OW-1:0]           occ_sum;
   logic [OW-1:0]           release_amt;
   logic [OW-1:0]           occ_next;
   logic                    accepting;
   logic                    pop;
   logic                    start_flag;
   logic                    end_flag;

   assign start_flag = in_data[IF_SCRATCH_WIDTH+1];
   assign end_flag   = in_data[IF_SCRATCH_WIDTH];
   assign full       = (occ == DEPTH_V);
   assign occupancy  = occ;
   assign IF_waddr   = waddr;
   assign IF_wdata   = in_data[IF_SCRATCH_WIDTH-1:0];

   // Handshake, write strobe, pointer increment and saturating occupancy update.
   always_comb begin
      accepting   = (state == IDLE) || (state == LOAD);
      in_ready    = accepting && !full && !stall_pipeline;
      pop         = in_valid && in_ready;
      // In IDLE only a start-tagged word opens a row; anything else is dropped.
      IF_wen      = pop && ((state == LOAD) || start_flag);
      waddr_inc   = (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
      release_amt = stride_done ? {1'b0, stride_len} : '0;
      occ_sum     = occ + {{IF_ADDR_LEN{1'b0}}, IF_wen};
      occ_next    = (occ_sum > release_amt) ? occ_sum - release_amt : '0;
   end

   // Row FSM with registered window, pointer, occupancy and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         waddr        <= '0;
         occ          <= '0;
         IF_start_pos <= '0;
         IF_end_pos   <= '0;
         IF_end_valid <= 1'b0;
         row_start    <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         row_start <= pop && (state == IDLE) && start_flag;
         if (IF_wen) waddr <= waddr_inc;
         // A completed row releases everything; otherwise writes and strides net out.
         if (row_done && state == WAIT_ROW) occ <= '0;
         else                               occ <= occ_next;
         if (row_done && state != WAIT_ROW) protocol_err <= 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  if (!start_flag) begin
                     protocol_err <= 1'b1;
                  end else if (end_flag) begin
                     IF_end_pos   <= waddr;
                     IF_end_valid <= 1'b1;
                     state        <= WAIT_ROW;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (pop) begin
                  // A stray start tag mid-row is stored as ordinary data.
                  if (start_flag) protocol_err <= 1'b1;
                  if (end_flag) begin
                     IF_end_pos   <= waddr;
                     IF_end_valid <= 1'b1;
                     state        <= WAIT_ROW;
                  end
               end
            end
            WAIT_ROW: begin
               // Row completion is honoured even while the pipeline is stalled.
               if (row_done) begin
                  IF_start_pos <= waddr;
                  IF_end_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_write_addr_gen.sv
// Bench for if_write_addr_gen: directed scenarios with spec constants plus a
// randomized run, all compared against a row/occupancy model kept here.
module tb_if_write_addr_gen;

   localparam int AL    = 4;
   localparam int DEPTH = 16;
   localparam int W     = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W+1:0]  in_data;
   logic          in_ready;
   logic          stall_pipeline;
   logic [AL-1:0] stride_len;
   logic          stride_done;
   logic          row_done;
   logic          IF_wen;
   logic [AL-1:0] IF_waddr;
   logic [W-1:0]  IF_wdata;
   logic [AL-1:0] IF_start_pos;
   logic [AL-1:0] IF_end_pos;
   logic          IF_end_valid;
   logic          row_start;
   logic          full;
   logic [AL:0]   occupancy;
   logic          protocol_err;

   int n_checks = 0;
   int n_fail   = 0;

   // model: row phase 0=waiting for start, 1=loading, 2=row complete
   int m_row, m_ptr, m_occ, m_start, m_end, m_endv, m_rs, m_err;
   // values seen just before the last edge and what the model expected then
   logic          obs_ready, obs_wen;
   logic [AL-1:0] obs_waddr;
   logic [W-1:0]  obs_wdata;
   logic          exp_ready, exp_wen;
   int            exp_waddr;
   logic [W-1:0]  exp_wdata;

   always #5 clk = ~clk;

   if_write_addr_gen #(.IF_ADDR_LEN(AL), .IF_SCRATCH_DEPTH(DEPTH), .IF_SCRATCH_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .stall_pipeline(stall_pipeline), .stride_len(stride_len), .stride_done(stride_done),
      .row_done(row_done), .IF_wen(IF_wen), .IF_waddr(IF_waddr), .IF_wdata(IF_wdata),
      .IF_start_pos(IF_start_pos), .IF_end_pos(IF_end_pos), .IF_end_valid(IF_end_valid),
      .row_start(row_start), .full(full), .occupancy(occupancy), .protocol_err(protocol_err)
   );

   task automatic model_reset();
      m_row = 0; m_ptr = 0; m_occ = 0; m_start = 0; m_end = 0; m_endv = 0; m_rs = 0; m_err = 0;
   endtask

   // One clock of stimulus; samples the DUT at the falling edge and advances the model.
   task automatic step(input logic v, input logic sf, input logic ef, input logic [W-1:0] d,
                       input logic st, input logic sd, input logic [AL-1:0] sl, input logic rd);
      int pre_row;
      logic pop;
      in_valid = v; in_data = {sf, ef, d}; stall_pipeline = st;
      stride_done = sd; stride_len = sl; row_done = rd;
      @(negedge clk);
      obs_ready = in_ready; obs_wen = IF_wen; obs_waddr = IF_waddr; obs_wdata = IF_wdata;
      exp_ready = (m_row != 2) && (m_occ < DEPTH) && !st;
      pop       = v && exp_ready;
      exp_wen   = pop && (m_row == 1 || sf);
      exp_waddr = m_ptr;
      exp_wdata = d;
      @(posedge clk);
      pre_row = m_row;
      m_rs = (pop && pre_row == 0 && sf) ? 1 : 0;
      if (pop && pre_row == 0 && !sf) m_err = 1;
      if (pop && pre_row == 1 && sf)  m_err = 1;
      if (exp_wen && ef) begin
         m_end = m_ptr; m_endv = 1; m_row = 2;
      end else if (exp_wen && pre_row == 0) begin
         m_row = 1;
      end
      if (exp_wen) m_ptr = (m_ptr + 1) % DEPTH;
      if (rd && pre_row == 2) begin
         m_occ = 0; m_start = m_ptr; m_endv = 0; m_row = 0;
      end else begin
         if (rd) m_err = 1;
         m_occ = m_occ + (exp_wen ? 1 : 0) - (sd ? int'(sl) : 0);
         if (m_occ < 0) m_occ = 0;
      end
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; stall_pipeline = 1'b0;
      stride_done = 1'b0; stride_len = '0; row_done = 1'b0;
      #1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1; #1;
      n_checks += 8;
      if (IF_waddr !== 0)     begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", IF_waddr); end
      if (IF_start_pos !== 0) begin n_fail++; $display("FAIL reset_start: got %0d want 0", IF_start_pos); end
      if (IF_end_pos !== 0)   begin n_fail++; $display("FAIL reset_end: got %0d want 0", IF_end_pos); end
      if (IF_end_valid !== 0) begin n_fail++; $display("FAIL reset_endv: got %0b want 0", IF_end_valid); end
      if (occupancy !== 0)    begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      if (row_start !== 0)    begin n_fail++; $display("FAIL reset_rowstart: got %0b want 0", row_start); end
      if (protocol_err !== 0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", protocol_err); end
      if (IF_wen !== 0)       begin n_fail++; $display("FAIL reset_wen: got %0b want 0", IF_wen); end
      rst = 1'b0;
   endtask

   // T1: 5-word row written at 0..4 back to back
   task automatic test_row();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, i == 0, i == 4, 16'(16'hA000 + i), 1'b0, 1'b0, '0, 1'b0);
         n_checks += 4;
         if (obs_wen !== 1'b1) begin n_fail++; $display("FAIL row_wen[%0d]: got %0b want 1", i, obs_wen); end
         if (obs_waddr !== AL'(i)) begin n_fail++; $display("FAIL row_waddr[%0d]: got %0d want %0d", i, obs_waddr, i); end
         if (obs_wdata !== 16'(16'hA000 + i)) begin n_fail++; $display("FAIL row_wdata[%0d]: got %h", i, obs_wdata); end
         if (row_start !== (i == 0)) begin n_fail++; $display("FAIL row_start[%0d]: got %0b want %0b", i, row_start, i == 0); end
      end
      n_checks += 5;
      if (IF_end_pos !== 4)   begin n_fail++; $display("FAIL row_endpos: got %0d want 4", IF_end_pos); end
      if (IF_end_valid !== 1) begin n_fail++; $display("FAIL row_endv: got %0b want 1", IF_end_valid); end
      if (IF_waddr !== 5)     begin n_fail++; $display("FAIL row_waddr_after: got %0d want 5", IF_waddr); end
      if (in_ready !== 0)     begin n_fail++; $display("FAIL row_ready_after: got %0b want 0", in_ready); end
      if (occupancy !== 5)    begin n_fail++; $display("FAIL row_occ: got %0d want 5", occupancy); end
   endtask

   // T2: row_done re-bases the window
   task automatic test_row_done();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      n_checks += 4;
      if (IF_start_pos !== 5) begin n_fail++; $display("FAIL rd_start: got %0d want 5", IF_start_pos); end
      if (IF_end_valid !== 0) begin n_fail++; $display("FAIL rd_endv: got %0b want 0", IF_end_valid); end
      if (occupancy !== 0)    begin n_fail++; $display("FAIL rd_occ: got %0d want 0", occupancy); end
      if (protocol_err !== 0) begin n_fail++; $display("FAIL rd_err: got %0b want 0", protocol_err); end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, i == 0, i == 2, 16'(i), 1'b0, 1'b0, '0, 1'b0);
         n_checks++;
         if (obs_waddr !== AL'(5 + i) || obs_wen !== 1'b1)
            begin n_fail++; $display("FAIL rd_next_row[%0d]: got addr %0d wen %0b want %0d", i, obs_waddr, obs_wen, 5 + i); end
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // T3: row starting at 14 wraps to 0
   task automatic test_wrap();
      int len;
      int want [4] = '{14, 15, 0, 1};
      len = (14 - m_ptr + DEPTH) % DEPTH;
      for (int i = 0; i < len; i++) step(1'b1, i == 0, i == len - 1, 16'(i), 1'b0, 1'b0, '0, 1'b0);
      if (len > 0) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (IF_start_pos !== 14) begin n_fail++; $display("FAIL wrap_start: got %0d want 14", IF_start_pos); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0, i == 3, 16'(16'hB0 + i), 1'b0, 1'b0, '0, 1'b0);
         n_checks++;
         if (obs_waddr !== AL'(want[i]) || obs_wen !== 1'b1)
            begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d wen %0b want %0d", i, obs_waddr, obs_wen, want[i]); end
      end
      n_checks += 2;
      if (IF_end_pos !== 1) begin n_fail++; $display("FAIL wrap_endpos: got %0d want 1", IF_end_pos); end
      if (IF_waddr !== 2)   begin n_fail++; $display("FAIL wrap_waddr: got %0d want 2", IF_waddr); end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // T4: overlong row stalls at full and resumes as strides release
   task automatic test_full();
      int k = 0;
      int extra = 0;
      for (int c = 0; c < 40 && k < 16; c++) begin
         step(1'b1, k == 0, k == 19, 16'(k), 1'b0, 1'b0, 4'd2, 1'b0);
         if (obs_wen) k++;
      end
      n_checks += 3;
      if (k !== 16)         begin n_fail++; $display("FAIL full_writes: got %0d want 16", k); end
      if (full !== 1)       begin n_fail++; $display("FAIL full_flag: got %0b want 1", full); end
      if (occupancy !== 16) begin n_fail++; $display("FAIL full_occ: got %0d want 16", occupancy); end
      step(1'b1, 1'b0, 1'b0, 16'(k), 1'b0, 1'b0, 4'd2, 1'b0);
      n_checks += 2;
      if (obs_ready !== 0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", obs_ready); end
      if (obs_wen !== 0)   begin n_fail++; $display("FAIL full_wen: got %0b want 0", obs_wen); end
      step(1'b1, 1'b0, 1'b0, 16'(k), 1'b0, 1'b1, 4'd2, 1'b0);
      n_checks++;
      if (occupancy !== 14) begin n_fail++; $display("FAIL full_release: got %0d want 14", occupancy); end
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 1'b0, k == 19, 16'(k), 1'b0, 1'b0, 4'd2, 1'b0);
         if (obs_wen) begin k++; extra++; end
      end
      n_checks += 2;
      if (extra !== 2) begin n_fail++; $display("FAIL full_extra: got %0d want 2", extra); end
      if (full !== 1)  begin n_fail++; $display("FAIL full_again: got %0b want 1", full); end
      for (int c = 0; c < 60 && m_row != 2; c++) begin
         step(1'b1, 1'b0, k == 19, 16'(k), 1'b0, 1'b1, 4'd2, 1'b0);
         if (obs_wen) k++;
      end
      n_checks++;
      if (k !== 20 || IF_end_valid !== 1)
         begin n_fail++; $display("FAIL full_complete: got %0d words endv %0b want 20 1", k, IF_end_valid); end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // T5: simultaneous write and release, and saturation at zero
   task automatic test_occ_math();
      for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'b0, 16'(i), 1'b0, 1'b0, '0, 1'b0);
      n_checks++;
      if (occupancy !== 10) begin n_fail++; $display("FAIL occ_fill: got %0d want 10", occupancy); end
      step(1'b1, 1'b0, 1'b0, 16'h55, 1'b0, 1'b1, 4'd3, 1'b0);
      n_checks += 2;
      if (obs_wen !== 1)   begin n_fail++; $display("FAIL occ_coinc_wen: got %0b want 1", obs_wen); end
      if (occupancy !== 8) begin n_fail++; $display("FAIL occ_coinc: got %0d want 8", occupancy); end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd7, 1'b0);
      n_checks++;
      if (occupancy !== 1) begin n_fail++; $display("FAIL occ_to1: got %0d want 1", occupancy); end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd3, 1'b0);
      n_checks++;
      if (occupancy !== 0) begin n_fail++; $display("FAIL occ_sat: got %0d want 0", occupancy); end
      step(1'b1, 1'b0, 1'b1, 16'h77, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   // T6: dropped word, stall, stray row_done, reset mid-row
   task automatic test_errors();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, '0, 1'b0);
      n_checks += 4;
      if (obs_ready !== 1)    begin n_fail++; $display("FAIL err_pop: got %0b want 1", obs_ready); end
      if (obs_wen !== 0)      begin n_fail++; $display("FAIL err_nowen: got %0b want 0", obs_wen); end
      if (protocol_err !== 1) begin n_fail++; $display("FAIL err_flag: got %0b want 1", protocol_err); end
      if (IF_waddr !== 0)     begin n_fail++; $display("FAIL err_waddr: got %0d want 0", IF_waddr); end
      do_reset();
      step(1'b1, 1'b1, 1'b0, 16'h1, 1'b1, 1'b0, '0, 1'b0);
      n_checks += 3;
      if (obs_ready !== 0) begin n_fail++; $display("FAIL stall_ready: got %0b want 0", obs_ready); end
      if (obs_wen !== 0)   begin n_fail++; $display("FAIL stall_wen: got %0b want 0", obs_wen); end
      if (IF_waddr !== 0)  begin n_fail++; $display("FAIL stall_waddr: got %0d want 0", IF_waddr); end
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      n_checks += 2;
      if (protocol_err !== 1) begin n_fail++; $display("FAIL stray_rd_err: got %0b want 1", protocol_err); end
      if (IF_start_pos !== 0) begin n_fail++; $display("FAIL stray_rd_start: got %0d want 0", IF_start_pos); end
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b0, 16'(i), 1'b0, 1'b0, '0, 1'b0);
      rst = 1'b1; #1;
      model_reset();
      n_checks += 3;
      if (IF_waddr !== 0 || occupancy !== 0) begin n_fail++; $display("FAIL midrst_regs: got waddr %0d occ %0d want 0 0", IF_waddr, occupancy); end
      if (IF_end_valid !== 0 || row_start !== 0 || protocol_err !== 0)
         begin n_fail++; $display("FAIL midrst_flags: got endv %0b rs %0b err %0b want 0", IF_end_valid, row_start, protocol_err); end
      if (IF_start_pos !== 0 || IF_end_pos !== 0) begin n_fail++; $display("FAIL midrst_window: got %0d %0d want 0 0", IF_start_pos, IF_end_pos); end
      @(posedge clk); #1; rst = 1'b0;
      // back in IDLE: a start word opens a fresh row at address 0
      step(1'b1, 1'b1, 1'b0, 16'h9, 1'b0, 1'b0, '0, 1'b0);
      n_checks += 2;
      if (obs_wen !== 1 || obs_waddr !== 0) begin n_fail++; $display("FAIL midrst_restart: got wen %0b addr %0d want 1 0", obs_wen, obs_waddr); end
      if (row_start !== 1) begin n_fail++; $display("FAIL midrst_rowstart: got %0b want 1", row_start); end
   endtask

   // Randomized traffic compared each cycle against the model.
   task automatic test_random();
      logic v, sf, ef, st, sd, rd;
      logic [AL-1:0] sl;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         v  = ($urandom_range(9) < 7);
         sf = (m_row == 0) ? ($urandom_range(9) != 0) : ($urandom_range(29) == 0);
         ef = ($urandom_range(5) == 0);
         st = ($urandom_range(9) == 0);
         sd = ($urandom_range(4) == 0);
         sl = AL'($urandom_range(5));
         rd = (m_row == 2) ? ($urandom_range(2) == 0) : ($urandom_range(99) == 0);
         step(v, sf, ef, 16'($urandom), st, sd, sl, rd);
         n_checks += 9;
         if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, obs_ready, exp_ready); end
         if (obs_wen !== exp_wen)     begin n_fail++; $display("FAIL rnd_wen c%0d: got %0b want %0b", c, obs_wen, exp_wen); end
         if (exp_wen && (obs_waddr !== AL'(exp_waddr) || obs_wdata !== exp_wdata))
            begin n_fail++; $display("FAIL rnd_wr c%0d: got %0d/%h want %0d/%h", c, obs_waddr, obs_wdata, exp_waddr, exp_wdata); end
         if (IF_waddr !== AL'(m_ptr))  begin n_fail++; $display("FAIL rnd_waddr c%0d: got %0d want %0d", c, IF_waddr, m_ptr); end
         if (occupancy !== (AL+1)'(m_occ)) begin n_fail++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, m_occ); end
         if (full !== (m_occ == DEPTH)) begin n_fail++; $display("FAIL rnd_full c%0d: got %0b", c, full); end
         if (IF_start_pos !== AL'(m_start) || IF_end_valid !== (m_endv != 0))
            begin n_fail++; $display("FAIL rnd_window c%0d: got %0d/%0b want %0d/%0d", c, IF_start_pos, IF_end_valid, m_start, m_endv); end
         if (m_endv != 0 && IF_end_pos !== AL'(m_end)) begin n_fail++; $display("FAIL rnd_end c%0d: got %0d want %0d", c, IF_end_pos, m_end); end
         if (row_start !== (m_rs != 0) || protocol_err !== (m_err != 0))
            begin n_fail++; $display("FAIL rnd_flags c%0d: got rs %0b err %0b want %0d %0d", c, row_start, protocol_err, m_rs, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_row();
      test_row_done();
      test_wrap();
      test_full();
      test_occ_math();
      test_errors();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
